nibble_serial_adder: RTL and testbench



---
 rtl/nibble_serial_adder_if.sv | 34 +++
 rtl/nibble_serial_adder.sv | 112 +++++++++++
 tb/tb_nibble_serial_adder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// +-----------------------------------------------------------------------------+
// | Module      : nibble_serial_adder_if                                        |
// | Description : Operand/result handshake bundle for the nibble-serial adder.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// +-----------------------------------------------------------------------------+
// | Module      : nibble_serial_adder                                           |
// | Description : WIDTH-bit adder sequenced through one 4-bit slice, LSB first. |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module nibble_serial_adder #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int                 c_IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_IDX_W-1:0] c_LAST  = c_IDX_W'(NIBBLES - 1);

  state_t             r_state;
  logic [c_IDX_W-1:0] r_idx;
  logic               r_carry;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [3:0]         w_na;
  logic [3:0]         w_nb;
  logic [4:0]         w_nsum;
  logic               w_c_msb;

  // The 4-bit slice: operand nibbles selected by the current index.
  always_comb begin
    w_na = '0;
    w_nb = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_na = r_a[4*i +: 4];
        w_nb = r_b[4*i +: 4];
      end
    end
    w_nsum  = {1'b0, w_na} + {1'b0, w_nb} + {4'b0000, r_carry};
    // Carry into the slice's top bit; on the last nibble this is the carry into bit WIDTH-1.
    w_c_msb = w_na[3] ^ w_nb[3] ^ w_nsum[3];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_idx   <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (r_idx == c_IDX_W'(i)) begin
              r_sum[4*i +: 4] <= w_nsum[3:0];
            end
          end
          r_carry <= w_nsum[4];
          r_idx   <= r_idx + 1'b1;
          if (r_idx == c_LAST) begin
            r_cout  <= w_nsum[4];
            r_ovf   <= w_c_msb ^ w_nsum[4];
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state == S_ADD) || (r_state == S_DONE);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// +-----------------------------------------------------------------------------+
// | Module      : tb_nibble_serial_adder                                        |
// | Description : Directed and random checks of nibble_serial_adder, WIDTH=16.  |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_nibble_serial_adder;

  localparam int WIDTH   = 16;
  localparam int NIBBLES = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                       output logic [WIDTH-1:0] s, output logic co, output logic ov);
    longint u;
    longint sv;
    u  = longint'(a) + longint'(b) + longint'(cin);
    sv = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    s  = u[WIDTH-1:0];
    co = (u >= (64'sd1 <<< WIDTH));
    ov = (sv > ((64'sd1 <<< (WIDTH-1)) - 1)) || (sv < -(64'sd1 <<< (WIDTH-1)));
  endtask

  // Present operands for one edge and return once out_valid is seen (bounded).
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                        output int lat);
    bus.a        = a;
    bus.b        = b;
    bus.cin      = cin;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom();
    bus.b        = $urandom();
    bus.cin      = 1'($urandom());
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin);
    int              lat;
    logic [WIDTH-1:0] es;
    logic            ec;
    logic            eo;
    model(a, b, cin, es, ec, eo);
    launch(a, b, cin, lat);
    check({tag, "_lat"}, lat, NIBBLES);
    check({tag, "_sum"}, bus.sum, es);
    check({tag, "_cout"}, bus.cout, ec);
    check({tag, "_ovf"}, bus.ovf, eo);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_idle_rdy"}, bus.in_ready, 1'b1);
    check({tag, "_hold_sum"}, bus.sum, es);
  endtask

  initial begin
    int              lat;
    logic [WIDTH-1:0] es;
    logic            ec;
    logic            eo;
    tests         = 0;
    failed        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b0;

    #2;
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_ovalid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_irdy", bus.in_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("basic", 16'h1234, 16'h4321, 1'b0);
    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
    run_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0);
    run_op("ovf_neg", 16'h8000, 16'h8000, 1'b0);
    run_op("cin_only", 16'h0000, 16'h0000, 1'b1);
    run_op("all_ones", 16'hFFFF, 16'hFFFF, 1'b1);

    // Backpressure: result held, new operands ignored while DONE.
    model(16'hA5A5, 16'h1234, 1'b1, es, ec, eo);
    launch(16'hA5A5, 16'h1234, 1'b1, lat);
    check("bp_lat", lat, NIBBLES);
    bus.a        = 16'h1111;
    bus.b        = 16'h1111;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_ovalid", bus.out_valid, 1'b1);
      check("bp_sum", bus.sum, es);
      check("bp_cout", bus.cout, ec);
      check("bp_irdy", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_release_irdy", bus.in_ready, 1'b1);
    check("bp_release_ovalid", bus.out_valid, 1'b0);
    check("bp_release_sum", bus.sum, es);

    // Asynchronous reset in the middle of an ADD.
    bus.a        = 16'hFFFF;
    bus.b        = 16'h0001;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum", bus.sum, 0);
    check("arst_cout", bus.cout, 0);
    check("arst_ovalid", bus.out_valid, 0);
    check("arst_irdy", bus.in_ready, 1);
    check("arst_busy", bus.busy, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 16'h0002, 16'h0003, 1'b0);

    // Random operands against the integer model.
    for (int n = 0; n < 24; n++) begin
      logic [WIDTH-1:0] ra;
      logic [WIDTH-1:0] rb;
      ra = WIDTH'($urandom());
      rb = WIDTH'($urandom());
      run_op("rand", ra, rb, 1'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
